pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying LANES issue slots as one atomic group, with
// whole-stage flush, per-lane kill and an optional one-entry skid buffer.
module pipe_stage_reg #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 64,
    parameter bit          SKID   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        pre_valid_i,
    input  logic [LANES*DATA_W-1:0] pre_data_i,
    output logic                    allowin_o,
    input  logic                    next_allowin_i,
    output logic [LANES-1:0]        now_valid_o,
    output logic [LANES*DATA_W-1:0] now_data_o,
    input  logic                    excep_flush_i,
    input  logic [LANES-1:0]        kill_mask_i,
    output logic                    skid_full_o
);

    localparam int unsigned W = LANES * DATA_W;

    logic [LANES-1:0] m_valid_q, m_valid_d;
    logic [LANES-1:0] s_valid_q, s_valid_d;
    logic [W-1:0]     m_data_q, m_data_d;
    logic [W-1:0]     s_data_q, s_data_d;
    logic             allowin_q, allowin_d;

    logic m_full, s_full, in_fire, out_fire;

    assign m_full   = |m_valid_q;
    assign s_full   = |s_valid_q;
    // With the skid buffer allowin is a flop, breaking the combinational chain upstream.
    assign allowin_o   = SKID ? allowin_q : (~m_full | next_allowin_i);
    assign in_fire     = |pre_valid_i & allowin_o;
    assign out_fire    = m_full & next_allowin_i;
    assign now_valid_o = m_valid_q;
    assign now_data_o  = m_data_q;
    assign skid_full_o = s_full;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (excep_flush_i) begin
            m_valid_d = '0;
            s_valid_d = '0;
        end else begin
            if (SKID) begin
                // A full S also refills M when a kill has left M empty.
                if (s_full && (out_fire || !m_full)) begin
                    m_valid_d = s_valid_q;
                    m_data_d  = s_data_q;
                    s_valid_d = '0;
                end else if (in_fire && (!m_full || out_fire)) begin
                    m_valid_d = pre_valid_i;
                    m_data_d  = pre_data_i;
                end else if (in_fire) begin
                    s_valid_d = pre_valid_i;
                    s_data_d  = pre_data_i;
                end else if (out_fire) begin
                    m_valid_d = '0;
                end
            end else begin
                if (in_fire) begin
                    m_valid_d = pre_valid_i;
                    m_data_d  = pre_data_i;
                end else if (out_fire) begin
                    m_valid_d = '0;
                end
            end
            m_valid_d = m_valid_d & ~kill_mask_i;
        end
        allowin_d = SKID ? ~|s_valid_d : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= '0;
            m_data_q  <= '0;
            s_valid_q <= '0;
            s_data_q  <= '0;
            allowin_q <= 1'b1;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            allowin_q <= allowin_d;
        end
    end

endmodule
